// File: rtl/ram_io_responder.sv
// Byte-wide RAM plus a memory-mapped byte-stream port: a tx FIFO drained by an
// external sink, an rx FIFO filled by an external source, and a status/clear register.

module ram_io_fifo #(
   parameter int W    = 8,
   parameter int LOG2 = 4
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);
   localparam int DEPTH = 1 << LOG2;
   localparam logic [LOG2:0] PTR_ONE = 1;

   logic [W-1:0] mem [DEPTH];
   logic [LOG2:0] wptr, rptr;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
      end
   end

   // Storage is not reset; a write during reset is harmless because wptr holds.
   always_ff @(posedge clk_in) begin
      if (push) mem[wptr[LOG2-1:0]] <= din;
   end

   assign head  = mem[rptr[LOG2-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[LOG2] != rptr[LOG2]) && (wptr[LOG2-1:0] == rptr[LOG2-1:0]);
endmodule

module ram_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_LOG2  = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        en_in,
   input  logic        r_or_w,
   input  logic [31:0] a_in,
   input  logic [7:0]  d_in,
   output logic [7:0]  d_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);
   logic [7:0] ram [2**ADDR_WIDTH];

   logic                  acc, io_sp, sel_data, sel_stat;
   logic                  wr_acc, rd_acc;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  tx_push, tx_pop, tx_drop, tx_empty, tx_full;
   logic                  rx_push, rx_pop, rx_empty, rx_full;
   logic [7:0]            rx_head, rd_data;
   logic                  tx_overflow;

   assign acc      = rdy_in & en_in;
   assign wr_acc   = acc & r_or_w;
   assign rd_acc   = acc & ~r_or_w;
   assign io_sp    = (a_in[31:16] == 16'h0003);
   assign sel_data = io_sp & (a_in[15:0] == 16'h0000);
   assign sel_stat = io_sp & (a_in[15:0] == 16'h0004);
   assign idx      = a_in[ADDR_WIDTH-1:0];

   // A full tx FIFO still takes the CPU byte when the sink frees a slot on the same edge.
   assign tx_pop   = tx_valid & tx_ready;
   assign tx_push  = wr_acc & sel_data & (~tx_full | tx_pop);
   assign tx_drop  = wr_acc & sel_data & tx_full & ~tx_pop;
   assign tx_valid = ~tx_empty;

   assign rx_ready = ~rx_full & ~rst_in;
   assign rx_push  = rx_valid & rx_ready;
   assign rx_pop   = rd_acc & sel_data & ~rx_empty;

   ram_io_fifo #(.W(8), .LOG2(FIFO_LOG2)) u_tx (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (tx_push),
      .pop    (tx_pop),
      .din    (d_in),
      .head   (tx_data),
      .empty  (tx_empty),
      .full   (tx_full)
   );

   ram_io_fifo #(.W(8), .LOG2(FIFO_LOG2)) u_rx (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (rx_push),
      .pop    (rx_pop),
      .din    (rx_data),
      .head   (rx_head),
      .empty  (rx_empty),
      .full   (rx_full)
   );

   always_comb begin
      rd_data = 8'h00;
      if (!io_sp)        rd_data = ram[idx];
      else if (sel_data) rd_data = rx_empty ? 8'h00 : rx_head;
      else if (sel_stat) rd_data = {5'b0, tx_overflow, ~rx_empty, tx_full};
   end

   // RAM lives in the reset block only so an edge seen while in reset cannot write;
   // its contents are never cleared.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         d_out       <= 8'h00;
         tx_overflow <= 1'b0;
      end else begin
         if (rd_acc) d_out <= rd_data;
         if (wr_acc && !io_sp) ram[idx] <= d_in;
         if (wr_acc && sel_stat) tx_overflow <= 1'b0;
         else if (tx_drop)       tx_overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: a vector table for single-cycle accesses,
// then hand sequences for FIFO fill/drain, rx handling and mid-stream reset.

module tb_ram_io_responder;
   logic        clk_in, rst_in, rdy_in, en_in, r_or_w;
   logic [31:0] a_in;
   logic [7:0]  d_in, d_out, tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready;

   int nvec = 0;
   int nerr = 0;

   ram_io_responder #(.ADDR_WIDTH(17), .FIFO_LOG2(4)) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .en_in    (en_in),
      .r_or_w   (r_or_w),
      .a_in     (a_in),
      .d_in     (d_in),
      .d_out    (d_out),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        rdy, en, rw;
      logic [31:0] addr;
      logic [7:0]  din;
      logic [7:0]  exp_d;
      logic        exp_txv;
   } vec_t;

   function automatic vec_t mk(input logic rdy, en, rw, input logic [31:0] addr,
                               input logic [7:0] din, exp_d, input logic exp_txv);
      vec_t v;
      v.rdy = rdy; v.en = en; v.rw = rw; v.addr = addr;
      v.din = din; v.exp_d = exp_d; v.exp_txv = exp_txv;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %02h want %02h", nm, act, exp);
      end
   endtask

   // Drive one access, take one edge, sample 1 time unit later.
   task automatic acc(input logic rdy, en, rw, input logic [31:0] a, input logic [7:0] d);
      rdy_in = rdy; en_in = en; r_or_w = rw; a_in = a; d_in = d;
      @(posedge clk_in);
      #1;
      en_in = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string nm);
      acc(1'b1, 1'b1, 1'b0, a, 8'h00);
      chk(nm, d_out, exp);
   endtask

   task automatic drain16(input logic [7:0] first, input logic [7:0] last);
      for (int i = 0; i < 16; i++) begin
         chk("drain_valid", {7'b0, tx_valid}, 8'h01);
         chk("drain_data", tx_data, (i < 15) ? first + 8'(i) : last);
         tx_ready = 1'b1;
         @(posedge clk_in);
         #1;
         tx_ready = 1'b0;
      end
      chk("drain_empty", {7'b0, tx_valid}, 8'h00);
   endtask

   vec_t tbl [14];

   initial begin
      tbl[0]  = mk(1, 1, 1, 32'h0000_0010, 8'hA5, 8'h00, 0);
      tbl[1]  = mk(1, 1, 0, 32'h0000_0010, 8'h00, 8'hA5, 0);
      tbl[2]  = mk(1, 1, 1, 32'h0001_FFFF, 8'h5A, 8'hA5, 0);
      tbl[3]  = mk(1, 1, 0, 32'h0005_FFFF, 8'h00, 8'h5A, 0);
      tbl[4]  = mk(1, 1, 1, 32'h0000_0020, 8'h77, 8'h5A, 0);
      tbl[5]  = mk(0, 1, 1, 32'h0000_0020, 8'h99, 8'h5A, 0);
      tbl[6]  = mk(1, 0, 1, 32'h0000_0020, 8'h88, 8'h5A, 0);
      tbl[7]  = mk(1, 1, 0, 32'h0000_0020, 8'h00, 8'h77, 0);
      tbl[8]  = mk(0, 1, 0, 32'h0000_0010, 8'h00, 8'h77, 0);
      tbl[9]  = mk(1, 1, 0, 32'h0003_0008, 8'h00, 8'h00, 0);
      tbl[10] = mk(1, 1, 0, 32'h0003_0004, 8'h00, 8'h00, 0);
      tbl[11] = mk(1, 1, 1, 32'h0003_0008, 8'hFF, 8'h00, 0);
      tbl[12] = mk(0, 1, 1, 32'h0003_0000, 8'h11, 8'h00, 0);
      tbl[13] = mk(1, 1, 0, 32'h0003_0000, 8'h00, 8'h00, 0);

      rdy_in = 1'b0; en_in = 1'b0; r_or_w = 1'b0; a_in = '0; d_in = '0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      rst_in = 1'b1;
      #1;
      chk("rst_dout", d_out, 8'h00);
      chk("rst_txv", {7'b0, tx_valid}, 8'h00);
      chk("rst_rxr", {7'b0, rx_ready}, 8'h00);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      #1;
      chk("post_rst_rxr", {7'b0, rx_ready}, 8'h01);

      for (int i = 0; i < 14; i++) begin
         acc(tbl[i].rdy, tbl[i].en, tbl[i].rw, tbl[i].addr, tbl[i].din);
         chk($sformatf("vec%0d_dout", i), d_out, tbl[i].exp_d);
         chk($sformatf("vec%0d_txv", i), {7'b0, tx_valid}, {7'b0, tbl[i].exp_txv});
      end
      rd(32'h0000_0020, 8'h77, "ram_after_gated_writes");

      // tx overflow: 17 writes into a 16-deep FIFO with the sink stalled
      for (int i = 0; i < 17; i++) acc(1'b1, 1'b1, 1'b1, 32'h0003_0000, 8'(i));
      chk("tx_head", tx_data, 8'h00);
      rd(32'h0003_0004, 8'h05, "stat_overflow_full");
      drain16(8'h00, 8'h0F);
      acc(1'b1, 1'b1, 1'b1, 32'h0003_0004, 8'hFF);
      rd(32'h0003_0004, 8'h00, "stat_cleared");

      // full FIFO accepts a CPU push on the same edge as an external pop
      for (int i = 0; i < 16; i++) acc(1'b1, 1'b1, 1'b1, 32'h0003_0000, 8'h20 + 8'(i));
      rd(32'h0003_0004, 8'h01, "stat_full");
      tx_ready = 1'b1;
      acc(1'b1, 1'b1, 1'b1, 32'h0003_0000, 8'hEE);
      tx_ready = 1'b0;
      rd(32'h0003_0004, 8'h01, "stat_full_no_ovf");
      drain16(8'h21, 8'hEE);

      // rx path
      rx_data = 8'h3C; rx_valid = 1'b1;
      @(posedge clk_in);
      #1;
      rx_valid = 1'b0;
      rd(32'h0003_0004, 8'h02, "stat_rx_nonempty");
      rd(32'h0003_0000, 8'h3C, "rx_pop");
      rd(32'h0003_0000, 8'h00, "rx_empty_read");
      rd(32'h0003_0004, 8'h00, "stat_rx_empty");

      // CPU reads empty rx on the same edge a byte arrives: no bypass
      rx_data = 8'h42; rx_valid = 1'b1;
      acc(1'b1, 1'b1, 1'b0, 32'h0003_0000, 8'h00);
      rx_valid = 1'b0;
      chk("rx_no_bypass", d_out, 8'h00);
      rd(32'h0003_0000, 8'h42, "rx_retained");

      for (int i = 0; i < 16; i++) begin
         rx_data = 8'h80 + 8'(i); rx_valid = 1'b1;
         @(posedge clk_in);
         #1;
      end
      rx_valid = 1'b0;
      chk("rx_full_ready", {7'b0, rx_ready}, 8'h00);
      rd(32'h0003_0004, 8'h02, "stat_rx_full");

      // reset mid-stream with a RAM write pending
      acc(1'b1, 1'b1, 1'b1, 32'h0000_0040, 8'hC3);
      for (int i = 0; i < 3; i++) acc(1'b1, 1'b1, 1'b1, 32'h0003_0000, 8'hD0 + 8'(i));
      chk("pre_rst_txv", {7'b0, tx_valid}, 8'h01);
      rdy_in = 1'b1; en_in = 1'b1; r_or_w = 1'b1; a_in = 32'h0000_0040; d_in = 8'h00;
      #2;
      rst_in = 1'b1;
      #1;
      chk("mid_rst_txv", {7'b0, tx_valid}, 8'h00);
      chk("mid_rst_rxr", {7'b0, rx_ready}, 8'h00);
      chk("mid_rst_dout", d_out, 8'h00);
      @(posedge clk_in);
      #1;
      en_in = 1'b0;
      rst_in = 1'b0;
      rd(32'h0000_0040, 8'hC3, "ram_kept_0x40");
      rd(32'h0000_0010, 8'hA5, "ram_kept_0x10");
      rd(32'h0003_0004, 8'h00, "stat_after_rst");
      chk("rxr_after_rst", {7'b0, rx_ready}, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
